aes128_req_arbiter: RTL and testbench

Shares one AES-128 encryption core between NUM_REQ independent requesters.
- Arbitrates round-robin and latches the winner's key/plaintext.
- Pulses the core's load, waits for the core's ready (nominal 505 cycles after load), returns the ciphertext tagged with the requester id.
- Sits between the host-side request ports and the single aes128 core instance; includes a watchdog that aborts a hung core operation.

---
 rtl/aes128_req_arbiter.sv | 165 ++++++++++++++++
 tb/tb_aes128_req_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : aes128_req_arbiter
// Purpose  : Round-robin sharing of one AES-128 core among NUM_REQ requesters,
//            with a watchdog that aborts a core operation that never completes.
// Revision : 1.0 - initial release
// ============================================================================
module aes128_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 600,
    parameter int CNT_W       = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*128-1:0] req_key_i,
    input  logic [NUM_REQ*128-1:0] req_data_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [127:0]           rsp_data_o,
    output logic                   rsp_err_o,
    output logic                   core_load_o,
    output logic [127:0]           core_key_o,
    output logic [127:0]           core_data_o,
    input  logic                   core_ready_i,
    input  logic [127:0]           core_data_i,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [127:0]     key_q, key_d;
    logic [127:0]     data_q, data_d;
    logic [127:0]     result_q, result_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] wd_q, wd_d;

    logic             w_any;
    logic [ID_W-1:0]  w_win;
    logic [ID_W:0]    w_idx;
    logic [ID_W:0]    w_nxt;
    logic [127:0]     w_key;
    logic [127:0]     w_data;

    // Scan from the highest offset down so the requester closest to rr_ptr wins.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        w_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (req_valid_i[w_idx[ID_W-1:0]]) begin
                w_any = 1'b1;
                w_win = w_idx[ID_W-1:0];
            end
        end
        w_key  = '0;
        w_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_win == ID_W'(k)) begin
                w_key  = req_key_i[k*128 +: 128];
                w_data = req_data_i[k*128 +: 128];
            end
        end
        w_nxt = {1'b0, w_win} + 1'b1;
        if (w_nxt == (ID_W+1)'(NUM_REQ)) begin
            w_nxt = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        key_d       = key_q;
        data_d      = data_q;
        result_d    = result_q;
        err_d       = err_q;
        wd_d        = wd_q;
        req_ready_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (w_any) begin
                    req_ready_o[w_win] = 1'b1;
                    key_d    = w_key;
                    data_d   = w_data;
                    id_d     = w_win;
                    rr_ptr_d = w_nxt[ID_W-1:0];
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A result arriving on the timeout cycle still takes priority.
                if (core_ready_i) begin
                    result_d = core_data_i;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end else if (wd_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            key_q    <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            key_q    <= key_d;
            data_q   <= data_d;
            result_q <= result_d;
            err_q    <= err_d;
            wd_q     <= wd_d;
        end
    end

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_id_o    = id_q;
    assign rsp_data_o  = result_q;
    assign rsp_err_o   = err_q;
    assign core_load_o = (state_q == ST_LOAD);
    assign core_key_o  = key_q;
    assign core_data_o = data_q;
    assign busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aes128_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes128_req_arbiter
// Purpose  : Self-checking bench for aes128_req_arbiter with a behavioural
//            AES-core stand-in and a round-robin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes128_req_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NUM_REQ-1:0]     req_valid_i = '0;
    logic [NUM_REQ-1:0]     req_ready_o;
    logic [NUM_REQ*128-1:0] req_key_i = '0;
    logic [NUM_REQ*128-1:0] req_data_i = '0;
    logic                   rsp_valid_o;
    logic                   rsp_ready_i = 1'b1;
    logic [ID_W-1:0]        rsp_id_o;
    logic [127:0]           rsp_data_o;
    logic                   rsp_err_o;
    logic                   core_load_o;
    logic [127:0]           core_key_o;
    logic [127:0]           core_data_o;
    logic                   core_ready_i = 1'b0;
    logic [127:0]           core_data_i = '0;
    logic                   busy_o;

    int n_pass = 0, n_checks = 0;
    int cyc = 0;
    int ptr = 0;                 // reference round-robin pointer
    int core_lat = 5;
    bit hung = 1'b0;
    int inject_at = -1;
    int cnt = 0;
    int loads = 0;
    int last_load = 0;
    logic [127:0] pend_ct = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    aes128_req_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(600), .CNT_W(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_key_i(req_key_i), .req_data_i(req_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .core_load_o(core_load_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
        .core_ready_i(core_ready_i), .core_data_i(core_data_i), .busy_o(busy_o)
    );

    // Stand-in cipher: the real C.1 answer for the FIPS vector, a keyed mix otherwise.
    function automatic logic [127:0] ct_of(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int i = 0; i < NUM_REQ; i++) if (v[(p + i) % NUM_REQ]) return (p + i) % NUM_REQ;
        return -1;
    endfunction

    // Core model: result appears core_lat cycles after the load cycle.
    always @(negedge clk) begin
        core_ready_i = 1'b0;
        if (!rst_n) cnt = 0;
        else begin
            if (cyc == inject_at) begin
                core_ready_i = 1'b1;
                core_data_i  = 128'hdead_beef_dead_beef_dead_beef_dead_beef;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0 && !hung) begin
                    core_ready_i = 1'b1;
                    core_data_i  = pend_ct;
                end
            end
            if (core_load_o) begin
                cnt = core_lat; pend_ct = ct_of(core_key_o, core_data_o);
                loads++; last_load = cyc;
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; req_valid_i = '0; rsp_ready_i = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1; ptr = 0;
        @(negedge clk); #1;
    endtask

    task automatic fill_keys();
        for (int k = 0; k < NUM_REQ; k++) begin
            req_key_i[k*128 +: 128]  = {$urandom(), $urandom(), $urandom(), $urandom()};
            req_data_i[k*128 +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
    endtask

    task automatic wait_grant(output int w, output bit ok);
        ok = 1'b0; w = -1;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (|req_ready_o) begin
                for (int k = 0; k < NUM_REQ; k++) if (req_ready_o[k]) w = k;
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            #1;
            if (rsp_valid_o) begin ok = 1'b1; return; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #3;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, core_load_o, busy_o, rsp_data_o, core_key_o, core_data_o} !== '0)
            $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        else n_pass++;
        apply_reset();
        n_checks++;
        if (busy_o !== 1'b0 || req_ready_o !== '0) $display("FAIL reset_idle: busy=%0b ready=%b required 0/0", busy_o, req_ready_o);
        else n_pass++;
    endtask

    task automatic test_fips();
        int w, tg, tr, l0; bit ok, okr;
        core_lat = 505; l0 = loads;
        req_key_i[2*128 +: 128] = FIPS_KEY; req_data_i[2*128 +: 128] = FIPS_PT;
        req_valid_i = 4'b0100;
        wait_grant(w, ok); tg = cyc;
        n_checks++;
        if (!ok || w != 2) $display("FAIL fips_grant: got %0d required 2", w); else n_pass++;
        ptr = 3;
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(okr); tr = cyc;
        n_checks++;
        if (!okr || tr - tg != 507) $display("FAIL fips_latency: got %0d required 507", tr - tg); else n_pass++;
        n_checks++;
        if (rsp_data_o !== FIPS_CT || rsp_id_o !== 2'd2 || rsp_err_o !== 1'b0)
            $display("FAIL fips_rsp: got id=%0d err=%0b data=%h required 2/0/%h", rsp_id_o, rsp_err_o, rsp_data_o, FIPS_CT);
        else n_pass++;
        n_checks++;
        if (loads - l0 != 1 || last_load != tg + 1) $display("FAIL fips_load: got %0d pulses at %0d required 1 at %0d", loads - l0, last_load, tg + 1);
        else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_round_robin();
        int w, exp; bit ok;
        apply_reset(); fill_keys(); core_lat = 5;
        req_valid_i = '1;
        for (int g = 0; g < 6; g++) begin
            exp = pick(req_valid_i, ptr);
            wait_grant(w, ok);
            n_checks++;
            if (!ok || w != exp || !$onehot(req_ready_o)) $display("FAIL rr_grant%0d: got %0d (%b) required %0d", g, w, req_ready_o, exp);
            else n_pass++;
            if (ok) ptr = (w + 1) % NUM_REQ;
            @(negedge clk); #1;
            n_checks++;
            if (req_ready_o !== '0) $display("FAIL rr_pulse%0d: got %b required 0", g, req_ready_o); else n_pass++;
            wait_rsp(ok);
            n_checks++;
            if (!ok || rsp_id_o !== ID_W'(exp) || rsp_data_o !== ct_of(req_key_i[exp*128 +: 128], req_data_i[exp*128 +: 128]))
                $display("FAIL rr_rsp%0d: got id=%0d data=%h required id=%0d", g, rsp_id_o, rsp_data_o, exp);
            else n_pass++;
            @(negedge clk); #1;
        end
        req_valid_i = '0;
    endtask

    task automatic test_rr_skip();
        int w; bit ok;
        apply_reset(); core_lat = 4;
        req_valid_i = 4'b0010;
        wait_grant(w, ok); ptr = 2;
        @(negedge clk); #1; req_valid_i = 4'b1010;
        wait_rsp(ok);
        @(negedge clk); #1;
        wait_grant(w, ok);
        n_checks++;
        if (!ok || w != 3 || w != pick(4'b1010, ptr)) $display("FAIL skip_first: got %0d required 3", w); else n_pass++;
        @(negedge clk); #1; req_valid_i = 4'b0010;
        wait_rsp(ok);
        n_checks++;
        if (!ok || rsp_id_o !== 2'd3) $display("FAIL skip_rsp: got %0d required 3", rsp_id_o); else n_pass++;
        @(negedge clk); #1;
        wait_grant(w, ok);
        n_checks++;
        if (!ok || w != 1) $display("FAIL skip_second: got %0d required 1", w); else n_pass++;
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok);
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        int w, bad; bit ok; logic [127:0] d0;
        apply_reset(); fill_keys(); core_lat = 6;
        rsp_ready_i = 1'b0; req_valid_i = 4'b0010;
        wait_grant(w, ok);
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok);
        d0 = rsp_data_o; req_valid_i = 4'b0001; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (!rsp_valid_o || rsp_data_o !== d0 || rsp_id_o !== 2'd1 || rsp_err_o !== 1'b0 || req_ready_o !== '0) bad++;
        end
        n_checks++;
        if (!ok || bad != 0 || d0 !== ct_of(req_key_i[128 +: 128], req_data_i[128 +: 128]))
            $display("FAIL bp_hold: got %0d unstable cycles data=%h required 0", bad, d0);
        else n_pass++;
        rsp_ready_i = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 4'b0001) $display("FAIL bp_release: got valid=%0b ready=%b required 0/0001", rsp_valid_o, req_ready_o);
        else n_pass++;
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok);
        n_checks++;
        if (!ok || rsp_id_o !== 2'd0) $display("FAIL bp_next: got %0d required 0", rsp_id_o); else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_timeout();
        int w, tr; bit ok;
        apply_reset(); fill_keys(); core_lat = 505; hung = 1'b1;
        rsp_ready_i = 1'b0; req_valid_i = 4'b1000;
        wait_grant(w, ok);
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok); tr = cyc;
        n_checks++;
        if (!ok || tr - last_load != 601) $display("FAIL to_latency: got %0d required 601", tr - last_load); else n_pass++;
        n_checks++;
        if (rsp_err_o !== 1'b1 || rsp_data_o !== '0 || rsp_id_o !== 2'd3)
            $display("FAIL to_rsp: got err=%0b id=%0d data=%h required 1/3/0", rsp_err_o, rsp_id_o, rsp_data_o);
        else n_pass++;
        inject_at = cyc + 1;
        repeat (2) @(negedge clk); #1;
        n_checks++;
        if (rsp_err_o !== 1'b1 || rsp_data_o !== '0) $display("FAIL to_late_pulse: got err=%0b data=%h required 1/0", rsp_err_o, rsp_data_o);
        else n_pass++;
        rsp_ready_i = 1'b1;
        @(negedge clk); #1;
        inject_at = cyc + 1;
        repeat (2) @(negedge clk); #1;
        n_checks++;
        if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) $display("FAIL to_idle_pulse: got busy=%0b valid=%0b required 0/0", busy_o, rsp_valid_o);
        else n_pass++;
        hung = 1'b0; core_lat = 7; req_valid_i = 4'b0001;
        wait_grant(w, ok);
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok);
        n_checks++;
        if (!ok || rsp_err_o !== 1'b0 || rsp_data_o !== ct_of(req_key_i[127:0], req_data_i[127:0]))
            $display("FAIL to_recover: got err=%0b data=%h", rsp_err_o, rsp_data_o);
        else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int w; bit ok;
        apply_reset(); fill_keys(); core_lat = 505;
        req_valid_i = 4'b0100;
        wait_grant(w, ok);
        @(negedge clk); #1; req_valid_i = '0;
        repeat (101) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({req_ready_o, rsp_valid_o, rsp_err_o, core_load_o, busy_o, rsp_id_o, rsp_data_o, core_key_o, core_data_o} !== '0)
            $display("FAIL mid_reset: got busy=%0b key=%h required all zero", busy_o, core_key_o);
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; ptr = 0; core_lat = 5;
        @(negedge clk); #1;
        req_valid_i = 4'b1010;
        wait_grant(w, ok);
        n_checks++;
        if (!ok || w != pick(4'b1010, ptr)) $display("FAIL mid_grant: got %0d required %0d", w, pick(4'b1010, ptr)); else n_pass++;
        @(negedge clk); #1; req_valid_i = '0;
        wait_rsp(ok);
        n_checks++;
        if (!ok || rsp_id_o !== 2'd1 || rsp_data_o !== ct_of(req_key_i[128 +: 128], req_data_i[128 +: 128]))
            $display("FAIL mid_rsp: got id=%0d data=%h required id=1", rsp_id_o, rsp_data_o);
        else n_pass++;
        @(negedge clk); #1;
    endtask

    task automatic test_random();
        apply_reset();
        for (int op = 0; op < 25; op++) begin
            logic [NUM_REQ-1:0] v;
            int exp, w, hold;
            bit ok, okr;
            logic [127:0] d0;
            fill_keys();
            core_lat = $urandom_range(1, 20);
            hold = $urandom_range(0, 3);
            v = NUM_REQ'($urandom_range(1, 15));
            exp = pick(v, ptr);
            rsp_ready_i = (hold == 0);
            req_valid_i = v;
            wait_grant(w, ok);
            n_checks++;
            if (!ok || w != exp || !$onehot(req_ready_o)) $display("FAIL rand_grant%0d: got %0d required %0d", op, w, exp);
            else n_pass++;
            if (ok) ptr = (w + 1) % NUM_REQ;
            @(negedge clk); #1; req_valid_i = '0;
            wait_rsp(okr);
            d0 = rsp_data_o;
            n_checks++;
            if (!okr || rsp_id_o !== ID_W'(exp) || rsp_err_o !== 1'b0 || d0 !== ct_of(req_key_i[exp*128 +: 128], req_data_i[exp*128 +: 128]))
                $display("FAIL rand_rsp%0d: got id=%0d data=%h required id=%0d", op, rsp_id_o, d0, exp);
            else n_pass++;
            if (hold > 0) begin
                repeat (hold) @(negedge clk);
                #1;
                n_checks++;
                if (!rsp_valid_o || rsp_data_o !== d0) $display("FAIL rand_hold%0d: got valid=%0b data=%h required 1/%h", op, rsp_valid_o, rsp_data_o, d0);
                else n_pass++;
                rsp_ready_i = 1'b1;
            end
            @(negedge clk); #1;
            n_checks++;
            if (rsp_valid_o !== 1'b0) $display("FAIL rand_drop%0d: got %0b required 0", op, rsp_valid_o); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_round_robin();
        test_rr_skip();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
